// File: rtl/fabric_req_arbiter.sv
// Two-initiator round-robin front end for the single-target storage fabric.
// Serialises one transaction at a time and returns the response (or a timeout error) to its initiator.
module fabric_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_valid,
    output logic             m0_ready,
    input  logic             m0_wr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_rsp_valid,
    output logic [WIDTH-1:0] m0_rsp_data,
    output logic             m0_rsp_err,
    input  logic             m1_valid,
    output logic             m1_ready,
    input  logic             m1_wr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_rsp_valid,
    output logic [WIDTH-1:0] m1_rsp_data,
    output logic             m1_rsp_err,
    output logic             t_read_req,
    output logic             t_write_req,
    output logic [WIDTH-1:0] t_write_data,
    input  logic [WIDTH-1:0] t_read_data,
    input  logic             t_resp_valid,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             grant_q, grant_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rd_req_q, rd_req_d;
    logic             wr_req_q, wr_req_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             win1;

    // M1 wins when it is the only requester or when the pointer favours it.
    assign win1     = m1_valid & (~m0_valid | rr_q);
    assign m0_ready = rst_n & (state_q == IDLE) & m0_valid & ~win1;
    assign m1_ready = rst_n & (state_q == IDLE) & win1;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_valid | m1_valid) begin
                    grant_d  = win1;
                    wr_d     = win1 ? m1_wr : m0_wr;
                    wdata_d  = win1 ? m1_wdata : m0_wdata;
                    rr_d     = ~win1;
                    wr_req_d = wr_d;
                    rd_req_d = ~wr_d;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (t_resp_valid) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_data_d           = wr_q ? '0 : t_read_data;
                    state_d              = RESP;
                // Counter runs 0..TIMEOUT, so the error lands TIMEOUT+2 cycles after the strobe.
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            grant_q     <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign t_read_req   = rd_req_q;
    assign t_write_req  = wr_req_q;
    assign t_write_data = wdata_q;
    assign busy         = (state_q != IDLE);

    assign m0_rsp_valid = rsp_valid_q[0];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m0_rsp_data  = rsp_valid_q[0] ? rsp_data_q : '0;
    assign m1_rsp_data  = rsp_valid_q[1] ? rsp_data_q : '0;
    assign m0_rsp_err   = rsp_valid_q[0] & rsp_err_q;
    assign m1_rsp_err   = rsp_valid_q[1] & rsp_err_q;
endmodule

// File: tb/tb_fabric_req_arbiter.sv
// Bench for fabric_req_arbiter: vector table plus hand-written corner sequences,
// with a response scoreboard checked against a simple single-register target model.
module tb_fabric_req_arbiter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             m0_valid = 1'b0, m0_wr = 1'b0, m1_valid = 1'b0, m1_wr = 1'b0;
    logic [WIDTH-1:0] m0_wdata = '0, m1_wdata = '0;
    logic             m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
    logic [WIDTH-1:0] m0_rsp_data, m1_rsp_data, t_write_data;
    logic [WIDTH-1:0] t_read_data = '0;
    logic             t_read_req, t_write_req, t_resp_valid, busy;

    always #5 clk = ~clk;

    fabric_req_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wr(m0_wr), .m0_wdata(m0_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_err(m0_rsp_err),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wr(m1_wr), .m1_wdata(m1_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_rsp_err(m1_rsp_err),
        .t_read_req(t_read_req), .t_write_req(t_write_req), .t_write_data(t_write_data),
        .t_read_data(t_read_data), .t_resp_valid(t_resp_valid), .busy(busy)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] wdata;
        bit          tgt;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          tgt_en  = 1'b1;
    bit          stray   = 1'b0;
    bit          tgt_resp = 1'b0;
    bit          pending = 1'b0;
    logic [31:0] tgt_mem = '0;
    bit          alt_on  = 1'b0;
    int          last_port = 1;

    assign t_resp_valid = tgt_resp | stray;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Target: one storage register, answers one cycle after each strobe.
    always @(negedge clk) begin
        tgt_resp = 1'b0;
        if (pending) begin
            tgt_resp    = 1'b1;
            t_read_data = tgt_mem;
            pending     = 1'b0;
        end
        if (tgt_en && rst_n && (t_read_req || t_write_req)) begin
            pending = 1'b1;
            if (t_write_req) tgt_mem = t_write_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            check("rsp_idle_zero",
                  {(!m0_rsp_valid && (m0_rsp_data != 0 || m0_rsp_err)),
                   (!m1_rsp_valid && (m1_rsp_data != 0 || m1_rsp_err))}, 0);
            check("rsp_onehot", m0_rsp_valid & m1_rsp_valid, 0);
            if (m0_rsp_valid ^ m1_rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", {m1_rsp_valid, m0_rsp_valid}, 0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_port", m1_rsp_valid ? 1 : 0, e.port);
                    check("rsp_data", m1_rsp_valid ? m1_rsp_data : m0_rsp_data, e.data);
                    check("rsp_err", m1_rsp_valid ? m1_rsp_err : m0_rsp_err, e.err);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic req(input int p, input bit wr, input logic [31:0] wd,
                       input logic [31:0] ed, input bit ee, input bit push);
        bit   ok;
        exp_t e;
        @(negedge clk);
        if (p == 0) begin m0_valid = 1'b1; m0_wr = wr; m0_wdata = wd; end
        else        begin m1_valid = 1'b1; m1_wr = wr; m1_wdata = wd; end
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if ((p == 0) ? m0_ready : m1_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("handshake", ok, 1);
        if (ok) begin
            if (push) begin
                e.port = p; e.data = ed; e.err = ee;
                e.cyc  = cyc + (ee ? TIMEOUT + 3 : 3);
                sbq.push_back(e);
            end
            if (alt_on) begin
                check("alternation", p, 1 - last_port);
                last_port = p;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (p == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        if (ok) begin
            check("strobe_wr", t_write_req, wr);
            check("strobe_rd", t_read_req, !wr);
            if (wr) check("strobe_wdata", t_write_data, wd);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #2;
            if (sbq.size() == 0 && !busy) break;
        end
        check("drain", {sbq.size() != 0, busy}, 0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
        tbl[1] = '{0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1, 1'b1, 32'h12345678, 1'b1, 32'h0,        1'b0};
        tbl[3] = '{1, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b0};
        tbl[4] = '{0, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b0};
        tbl[5] = '{1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[6] = '{0, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0};
        tbl[7] = '{1, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0};

        // Reset held with random inputs: every output must be low.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m0_valid = 1'($urandom); m0_wr = 1'($urandom); m0_wdata = $urandom;
            m1_valid = 1'($urandom); m1_wr = 1'($urandom); m1_wdata = $urandom;
            stray    = 1'($urandom);
            #1;
            check("reset_outputs", {m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err,
                  m1_rsp_err, t_read_req, t_write_req, busy, |m0_rsp_data, |m1_rsp_data,
                  |t_write_data}, 0);
        end
        @(negedge clk);
        m0_valid = 1'b0; m1_valid = 1'b0; stray = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_idle", {busy, t_read_req, t_write_req}, 0);
        end

        for (int i = 0; i < 8; i++) begin
            tgt_en = tbl[i].tgt;
            req(tbl[i].port, tbl[i].wr, tbl[i].wdata, tbl[i].exp_data, tbl[i].exp_err, 1'b1);
            drain();
        end
        tgt_en = 1'b1;

        // Stray target response while idle.
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        #1 check("stray_idle_busy", busy, 0);
        drain();

        // Stray target response during ISSUE.
        @(negedge clk);
        m0_valid = 1'b1; m0_wr = 1'b0;
        #1 check("stray_issue_ready", m0_ready, 1);
        begin
            exp_t e;
            e.port = 0; e.data = 32'hA5A5A5A5; e.err = 1'b0; e.cyc = cyc + 3;
            sbq.push_back(e);
        end
        @(negedge clk);
        m0_valid = 1'b0; stray = 1'b1;
        check("stray_issue_state", {busy, t_read_req}, 2'b11);
        @(negedge clk);
        stray = 1'b0;
        drain();

        // Fresh reset, then both initiators contend back-to-back.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        alt_on = 1'b1; last_port = 1;
        fork
            for (int k = 0; k < 10; k++) req(0, 1'b1, 32'h1000 + k, 32'h0, 1'b0, 1'b1);
            for (int k = 0; k < 10; k++) req(1, 1'b0, 32'h0, 32'h1000 + k, 1'b0, 1'b1);
        join
        alt_on = 1'b0;
        drain();

        // Reset while waiting on the target: the transaction vanishes.
        tgt_en = 1'b0;
        req(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("wait_state_busy", busy, 1);
        rst_n = 1'b0;
        #1 check("abort_outputs", {busy, t_read_req, t_write_req, m0_rsp_valid, m1_rsp_valid}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TIMEOUT + 6) @(negedge clk);
        check("abort_no_resp", sbq.size(), 0);
        tgt_en = 1'b1;
        req(1, 1'b0, 32'h0, 32'h1009, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
